// File: rtl/lane_ext_pkg.sv
// Shared sizing helpers for the lane extender: internal extend width and the
// compare width that holds both the shifted value and the output clamp bounds.
package lane_ext_pkg;

    function automatic int calc_w(input int in_size, input int shift_w);
        return in_size + (1 << shift_w) - 1;
    endfunction

    function automatic int calc_cw(input int in_size, input int out_size, input int shift_w);
        int w;
        w = calc_w(in_size, shift_w);
        return ((w > out_size) ? w : out_size) + 1;
    endfunction

endpackage

// File: rtl/lane_ext_lane.sv
// Single-lane extend / left-shift / clamp, purely combinational.
module lane_ext_lane
    import lane_ext_pkg::*;
#(
    parameter int IN_SIZE  = 8,
    parameter int OUT_SIZE = 16,
    parameter int SHIFT_W  = 4
) (
    input  logic [IN_SIZE-1:0]  in_i,
    input  logic                signed_i,
    input  logic [SHIFT_W-1:0]  shift_i,
    output logic [OUT_SIZE-1:0] out_o,
    output logic                sat_o
);

    // One extra bit beyond max(W, OUT_SIZE) keeps the unsigned upper bound positive.
    localparam int CW = calc_cw(IN_SIZE, OUT_SIZE, SHIFT_W);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] SMAX = (ONE << (OUT_SIZE - 1)) - ONE;
    localparam logic [CW-1:0] SMIN = ~SMAX;
    localparam logic [CW-1:0] UMAX = (ONE << OUT_SIZE) - ONE;

    logic          fill;
    logic [CW-1:0] ext;
    logic [CW-1:0] shifted;

    always_comb begin
        fill    = signed_i & in_i[IN_SIZE-1];
        ext     = {{(CW - IN_SIZE){fill}}, in_i};
        shifted = ext << shift_i;
        out_o   = shifted[OUT_SIZE-1:0];
        sat_o   = 1'b0;
        if (signed_i) begin
            if ($signed(shifted) > $signed(SMAX)) begin
                out_o = SMAX[OUT_SIZE-1:0];
                sat_o = 1'b1;
            end else if ($signed(shifted) < $signed(SMIN)) begin
                out_o = SMIN[OUT_SIZE-1:0];
                sat_o = 1'b1;
            end
        end else if (shifted > UMAX) begin
            out_o = UMAX[OUT_SIZE-1:0];
            sat_o = 1'b1;
        end
    end

endmodule

// File: rtl/lane_extender.sv
// Multi-lane handshaked sign/zero extender with shift, saturation, a 2-entry
// output FIFO and a sticky saturation event counter.
module lane_extender
    import lane_ext_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int IN_SIZE   = 8,
    parameter int OUT_SIZE  = 16,
    parameter int SHIFT_W   = 4,
    parameter int CNT_W     = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [NUM_LANES*IN_SIZE-1:0]  in_data_i,
    input  logic                          in_signed_i,
    input  logic [SHIFT_W-1:0]            in_shift_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [NUM_LANES*OUT_SIZE-1:0] out_data_o,
    output logic [NUM_LANES-1:0]          out_sat_o,
    output logic [CNT_W-1:0]              sat_cnt_o,
    input  logic                          sat_cnt_clr_i
);

    localparam int DW   = NUM_LANES * OUT_SIZE;
    localparam int PW   = $clog2(NUM_LANES + 1);
    localparam int SUMW = CNT_W + PW;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef struct packed {
        logic [DW-1:0]        data;
        logic [NUM_LANES-1:0] sat;
    } entry_t;

    generate
        if (OUT_SIZE < IN_SIZE) begin : g_bad_size
            $error("lane_extender: OUT_SIZE must be >= IN_SIZE");
        end
    endgenerate

    logic [DW-1:0]        lane_data;
    logic [NUM_LANES-1:0] lane_sat;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        lane_ext_lane #(
            .IN_SIZE (IN_SIZE),
            .OUT_SIZE(OUT_SIZE),
            .SHIFT_W (SHIFT_W)
        ) u_lane (
            .in_i    (in_data_i[k*IN_SIZE +: IN_SIZE]),
            .signed_i(in_signed_i),
            .shift_i (in_shift_i),
            .out_o   (lane_data[k*OUT_SIZE +: OUT_SIZE]),
            .sat_o   (lane_sat[k])
        );
    end

    entry_t          mem_q [2];
    entry_t          mem_d [2];
    logic            rd_ptr_q, rd_ptr_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic [1:0]      count_q, count_d;
    logic            in_ready_q, in_ready_d;
    logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;

    logic            push;
    logic            pop;
    logic [PW-1:0]   sat_pop;
    logic [SUMW-1:0] sat_sum;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        push     = in_valid_i & in_ready_q;
        pop      = (count_q != 2'd0) & out_ready_i;

        if (push) begin
            mem_d[wr_ptr_q] = '{data: lane_data, sat: lane_sat};
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d    = count_q + {1'b0, push} - {1'b0, pop};
        // Registered so out_ready_i never reaches in_ready_o combinationally.
        in_ready_d = (count_d != 2'd2);

        sat_pop = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            sat_pop = sat_pop + PW'(lane_sat[k]);
        end
        sat_sum   = SUMW'(sat_cnt_q) + SUMW'(sat_pop);
        sat_cnt_d = sat_cnt_q;
        if (sat_cnt_clr_i) begin
            sat_cnt_d = '0;
        end else if (push) begin
            sat_cnt_d = (sat_sum > SUMW'(CNT_MAX)) ? CNT_MAX : sat_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b0;
            sat_cnt_q  <= '0;
        end else begin
            mem_q      <= mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            sat_cnt_q  <= sat_cnt_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = mem_q[rd_ptr_q].data;
    assign out_sat_o   = mem_q[rd_ptr_q].sat;
    assign sat_cnt_o   = sat_cnt_q;

endmodule

// File: tb/tb_lane_extender.sv
// Randomized scoreboard bench for lane_extender with directed corner cases.
module tb_lane_extender;

    typedef struct {
        logic [63:0] d;
        logic [3:0]  s;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready_o;
    logic [31:0] in_data = '0;
    logic        in_signed = 1'b0;
    logic [3:0]  in_shift = '0;
    logic        out_valid_o;
    logic        out_ready = 1'b0;
    logic [63:0] out_data_o;
    logic [3:0]  out_sat_o;
    logic [15:0] sat_cnt_o;
    logic        sat_clr = 1'b0;

    logic        v2_valid = 1'b0;
    logic [31:0] v2_data = '0;
    logic        v2_signed = 1'b1;
    logic [3:0]  v2_shift = 4'd15;
    logic        v2_out_ready = 1'b1;
    logic        v2_clr = 1'b0;
    logic        u2_in_ready, u2_out_valid;
    logic [63:0] u2_out_data;
    logic [3:0]  u2_out_sat;
    logic [3:0]  u2_sat_cnt;

    int   checks = 0;
    int   failures = 0;
    int   acc_cnt = 0;
    int   sat_model = 0;
    bit   rnd_bp = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    lane_extender dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready_o), .in_data_i(in_data),
        .in_signed_i(in_signed), .in_shift_i(in_shift),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready),
        .out_data_o(out_data_o), .out_sat_o(out_sat_o),
        .sat_cnt_o(sat_cnt_o), .sat_cnt_clr_i(sat_clr)
    );

    lane_extender #(.CNT_W(4)) u2 (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(v2_valid), .in_ready_o(u2_in_ready), .in_data_i(v2_data),
        .in_signed_i(v2_signed), .in_shift_i(v2_shift),
        .out_valid_o(u2_out_valid), .out_ready_i(v2_out_ready),
        .out_data_o(u2_out_data), .out_sat_o(u2_out_sat),
        .sat_cnt_o(u2_sat_cnt), .sat_cnt_clr_i(v2_clr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: lane value as an integer, scaled by 2^shift, clamped to the output range.
    function automatic void model(input logic [31:0] d, input bit s, input int sh,
                                  output logic [63:0] od, output logic [3:0] os, output int ns);
        longint v;
        logic [63:0] t;
        logic [7:0]  b;
        ns = 0;
        od = '0;
        os = '0;
        for (int k = 0; k < 4; k++) begin
            b = d[k*8 +: 8];
            v = s ? longint'($signed(b)) : longint'({56'd0, b});
            v = v * (longint'(1) << sh);
            if (s && v > 32767)        begin v = 32767;  os[k] = 1'b1; end
            else if (s && v < -32768)  begin v = -32768; os[k] = 1'b1; end
            else if (!s && v > 65535)  begin v = 65535;  os[k] = 1'b1; end
            if (os[k]) ns++;
            t = v;
            od[k*16 +: 16] = t[15:0];
        end
    endfunction

    task automatic send(input logic [31:0] d, input bit s, input int sh);
        exp_t e;
        int   ns;
        int   waited = 0;
        bit   done = 0;
        model(d, s, sh, e.d, e.s, ns);
        in_data   = d;
        in_signed = s;
        in_shift  = 4'(sh);
        in_valid  = 1'b1;
        while (!done) begin
            if (in_ready_o) begin
                exp_q.push_back(e);
                acc_cnt++;
                sat_model = sat_clr ? 0 : ((sat_model + ns > 65535) ? 65535 : sat_model + ns);
                done = 1;
            end else if (waited >= 200) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout: in_ready_o stayed 0 for %0d cycles, expected 1", waited);
                done = 1;
            end
            @(posedge clk);
            @(negedge clk);
            waited++;
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Monitor: a transfer happens on the next rising edge if valid && ready now.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && out_valid_o && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got data 0x%0h, expected no output", out_data_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_data", out_data_o, e.d);
                    chk("sb_sat", {60'd0, out_sat_o}, {60'd0, e.s});
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    logic [31:0] dir_d  [7] = '{32'h80808080, 32'h80808080, 32'h7F7F7F7F, 32'h80808080,
                                32'h01010101, 32'hFFFFFFFF, 32'hFFFFFFFF};
    bit          dir_s  [7] = '{1, 0, 1, 1, 1, 0, 0};
    int          dir_sh [7] = '{0, 0, 9, 9, 9, 8, 9};
    logic [63:0] dir_od [7] = '{64'hFF80FF80FF80FF80, 64'h0080008000800080, 64'h7FFF7FFF7FFF7FFF,
                                64'h8000800080008000, 64'h0200020002000200, 64'hFF00FF00FF00FF00,
                                64'hFFFFFFFFFFFFFFFF};
    logic [3:0]  dir_os [7] = '{4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF};

    initial begin
        time t0;
        int  n;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready_o}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
        chk("rst_out_data", out_data_o, 64'd0);
        chk("rst_out_sat", {60'd0, out_sat_o}, 64'd0);
        chk("rst_sat_cnt", {48'd0, sat_cnt_o}, 64'd0);
        rst = 1'b0;
        idle(1);
        chk("ready_after_rst", {63'd0, in_ready_o}, 64'd1);

        // Directed arithmetic cases, each visible one cycle after acceptance.
        out_ready = 1'b1;
        chk("empty_before", {63'd0, out_valid_o}, 64'd0);
        for (int i = 0; i < 7; i++) begin
            send(dir_d[i], dir_s[i], dir_sh[i]);
            chk("dir_valid", {63'd0, out_valid_o}, 64'd1);
            chk("dir_data", out_data_o, dir_od[i]);
            chk("dir_sat", {60'd0, out_sat_o}, {60'd0, dir_os[i]});
        end
        idle(2);

        // Backpressure: 5 transactions against a stalled sink.
        out_ready = 1'b0;
        acc_cnt = 0;
        fork
            for (int i = 0; i < 5; i++) send(32'h10203040 + 32'(i), 1'b1, i);
            begin
                repeat (6) @(negedge clk);
                chk("bp_accepts", 64'(acc_cnt), 64'd2);
                chk("bp_in_ready", {63'd0, in_ready_o}, 64'd0);
                out_ready = 1'b1;
            end
        join
        idle(3);
        chk("bp_drained", 64'(exp_q.size()), 64'd0);

        // Throughput with the sink always ready.
        t0 = $time;
        for (int i = 0; i < 8; i++) send($urandom, 1'b0, 0);
        chk("throughput_cycles", 64'(($time - t0) / 10), 64'd8);
        idle(2);

        // Saturation counter.
        sat_clr = 1'b1;
        idle(1);
        sat_clr = 1'b0;
        sat_model = 0;
        chk("cnt_cleared", {48'd0, sat_cnt_o}, 64'd0);
        for (int i = 0; i < 3; i++) send(32'h7F7F7F7F, 1'b1, 15);
        chk("cnt_12", {48'd0, sat_cnt_o}, 64'd12);
        sat_clr = 1'b1;
        send(32'h80808080, 1'b1, 15);
        sat_clr = 1'b0;
        chk("cnt_clr_priority", {48'd0, sat_cnt_o}, 64'd0);
        idle(2);

        // Narrow counter sticks at its maximum.
        v2_data  = 32'h7F7F7F7F;
        v2_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("u2_ready", {63'd0, u2_in_ready}, 64'd1);
            idle(1);
            if (i == 2) chk("u2_cnt_12", {60'd0, u2_sat_cnt}, 64'd12);
        end
        v2_valid = 1'b0;
        chk("u2_cnt_stick", {60'd0, u2_sat_cnt}, 64'd15);

        // Randomized traffic with random backpressure.
        rnd_bp = 1;
        for (int i = 0; i < 150; i++) begin
            send($urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        rnd_bp = 0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            idle(1);
            n++;
        end
        chk("rnd_drained", 64'(exp_q.size()), 64'd0);
        chk("rnd_sat_cnt", {48'd0, sat_cnt_o}, 64'(sat_model));

        // Asynchronous reset with a full FIFO.
        out_ready = 1'b0;
        send(32'h7F7F7F7F, 1'b1, 15);
        send(32'h80808080, 1'b1, 15);
        chk("full_not_ready", {63'd0, in_ready_o}, 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", {63'd0, out_valid_o}, 64'd0);
        chk("arst_sat_cnt", {48'd0, sat_cnt_o}, 64'd0);
        chk("arst_out_data", out_data_o, 64'd0);
        exp_q.delete();
        sat_model = 0;
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        chk("post_rst_ready", {63'd0, in_ready_o}, 64'd1);
        out_ready = 1'b1;
        idle(3);
        chk("post_rst_no_out", {63'd0, out_valid_o}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
